// File: rtl/rv_alu_pkg.sv
// Shared ALU-control codes, RV32I opcodes and funct fields.
// Also used by the ALU-control generator, so the encoder shares its encode helpers.
package rv_alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_SLT     = 4'd3;
    localparam logic [3:0] ALU_SLTU    = 4'd4;
    localparam logic [3:0] ALU_XOR     = 4'd5;
    localparam logic [3:0] ALU_SRL     = 4'd6;
    localparam logic [3:0] ALU_SRA     = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_AND     = 4'd9;
    localparam logic [3:0] ALU_INVALID = 4'hF;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [3:0]  alu_control;
        logic        imm_mode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } enc_req_t;

    function automatic logic [2:0] alu_funct3(input logic [3:0] ctrl);
        logic [2:0] f3;
        f3 = F3_ADD_SUB;
        case (ctrl)
            ALU_SLL:          f3 = F3_SLL;
            ALU_SLT:          f3 = F3_SLT;
            ALU_SLTU:         f3 = F3_SLTU;
            ALU_XOR:          f3 = F3_XOR;
            ALU_SRL, ALU_SRA: f3 = F3_SRL_SRA;
            ALU_OR:           f3 = F3_OR;
            ALU_AND:          f3 = F3_AND;
            default:          f3 = F3_ADD_SUB;
        endcase
        return f3;
    endfunction

    function automatic logic [6:0] alu_funct7(input logic [3:0] ctrl);
        return (ctrl == ALU_SUB || ctrl == ALU_SRA) ? F7_ALT : F7_BASE;
    endfunction

    // No SUBI exists in RV32I, so SUB is only legal in register form.
    function automatic logic alu_is_legal(input logic [3:0] ctrl, input logic imm_mode);
        return (ctrl <= ALU_AND) && !(ctrl == ALU_SUB && imm_mode);
    endfunction

    function automatic logic [31:0] encode(input enc_req_t r);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm_field;
        logic        is_shift;
        f3       = alu_funct3(r.alu_control);
        f7       = alu_funct7(r.alu_control);
        is_shift = (r.alu_control == ALU_SLL) || (r.alu_control == ALU_SRL) ||
                   (r.alu_control == ALU_SRA);
        imm_field = is_shift ? {f7, r.imm[4:0]} : r.imm;
        if (r.imm_mode)
            return {imm_field, r.rs1, f3, r.rd, OPC_OP_IMM};
        return {f7, r.rs2, r.rs1, f3, r.rd, OPC_OP};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a head-word output.
// Storage is cleared on reset so the head reads zero when empty after reset.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU-operation requests into RV32I OP / OP-IMM words, buffered in a FIFO.
// Invalid requests are consumed, counted and flagged but never pushed.
module instr_encoder
    import rv_alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_control,
    input  logic             in_imm_mode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [11:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_invalid,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] rej_count
);

    enc_req_t    req;
    logic [31:0] enc_word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;

    always_comb begin
        req             = '0;
        req.alu_control = in_alu_control;
        req.imm_mode    = in_imm_mode;
        req.rd          = in_rd;
        req.rs1         = in_rs1;
        req.rs2         = in_rs2;
        req.imm         = in_imm;
    end

    assign enc_word = encode(req);
    assign legal    = alu_is_legal(in_alu_control, in_imm_mode);

    // Ready comes from registered FIFO state only; a same-cycle pop does not open a slot.
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = !fifo_empty;

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (out_ready),
        .rdata (out_instr),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_invalid <= 1'b0;
            enc_count   <= '0;
            rej_count   <= '0;
        end else begin
            err_invalid <= accept && !legal;
            if (push)
                enc_count <= enc_count + 1'b1;
            if (accept && !legal)
                rej_count <= rej_count + 1'b1;
        end
    end

endmodule
